// File: rtl/counter_sequencer_if.sv
// Wishbone classic slave bus used by counter_sequencer.
interface counter_sequencer_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;

  modport master (output cyc, stb, we, sel, adr, dat_w, input dat_r, ack);
  modport slave  (input cyc, stb, we, sel, adr, dat_w, output dat_r, ack);
endinterface

// File: rtl/counter_sequencer.sv
// Wishbone-controlled run/stop/reload sequencer for an external counter,
// with programmable compare, match counter and level interrupt.
module counter_sequencer #(
  parameter int unsigned BITS = 32
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  counter_sequencer_if.slave  wbs,
  output logic                ctr_load_o,
  output logic [BITS-1:0]     ctr_load_data_o,
  output logic                ctr_en_o,
  input  logic [BITS-1:0]     ctr_count_i,
  output logic                irq_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  state_t          state, state_next;
  logic [BITS-1:0] load_q, cmp_q;
  logic            pause_q, auto_q, irq_en_q, done_q;
  logic [15:0]     matches_q;

  logic            req, wr, ctrl_wr;
  logic            stop, start, done_clr, match, match_evt;
  logic [31:0]     rd_data;
  logic            unused;

  assign unused = ^{wbs.adr[31:4], wbs.adr[1:0]};

  function automatic logic [31:0] merge(input logic [31:0] old_val,
                                        input logic [31:0] new_val,
                                        input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int unsigned i = 0; i < 4; i++)
      if (sel[i]) res[8*i +: 8] = new_val[8*i +: 8];
    return res;
  endfunction

  always_comb begin
    req      = wbs.cyc & wbs.stb & ~wbs.ack;
    wr       = req & wbs.we;
    ctrl_wr  = wr && (wbs.adr[3:2] == 2'd0);
    stop     = ctrl_wr & wbs.sel[0] & wbs.dat_w[1];
    start    = ctrl_wr & wbs.sel[0] & wbs.dat_w[0] & ~stop;
    done_clr = ctrl_wr & wbs.sel[1] & wbs.dat_w[8];
    match    = ctr_count_i >= cmp_q;
    // A restart still records a match seen in the same RUN cycle; only STOP and PAUSE suppress it.
    match_evt = (state == ST_RUN) && !pause_q && match && !stop;
  end

  always_comb begin
    state_next = state;
    if (stop)
      state_next = ST_IDLE;
    else if (start)
      state_next = ST_LOAD;
    else begin
      case (state)
        ST_LOAD:  state_next = pause_q ? ST_PAUSE : ST_RUN;
        ST_RUN: begin
          if (pause_q)    state_next = ST_PAUSE;
          else if (match) state_next = auto_q ? ST_LOAD : ST_IDLE;
        end
        ST_PAUSE: if (!pause_q) state_next = ST_RUN;
        default:  state_next = state;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (wbs.adr[3:2])
      2'd0: rd_data = {matches_q, 5'b0, 2'(state), done_q, 3'b0,
                       irq_en_q, auto_q, pause_q, 2'b0};
      2'd1: rd_data = 32'(load_q);
      2'd2: rd_data = 32'(cmp_q);
      2'd3: rd_data = 32'(ctr_count_i);
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state      <= ST_IDLE;
      ctr_load_o <= 1'b0;
      ctr_en_o   <= 1'b0;
      load_q     <= '0;
      cmp_q      <= '0;
      pause_q    <= 1'b0;
      auto_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      matches_q  <= '0;
      wbs.ack    <= 1'b0;
      wbs.dat_r  <= '0;
    end else begin
      wbs.ack <= req;
      if (req) wbs.dat_r <= rd_data;

      // Outputs are the decode of the state being entered, so they track the state register.
      state      <= state_next;
      ctr_load_o <= (state_next == ST_LOAD);
      ctr_en_o   <= (state_next == ST_RUN);

      if (wr && wbs.adr[3:2] == 2'd1) load_q <= BITS'(merge(32'(load_q), wbs.dat_w, wbs.sel));
      if (wr && wbs.adr[3:2] == 2'd2) cmp_q  <= BITS'(merge(32'(cmp_q), wbs.dat_w, wbs.sel));
      if (ctrl_wr && wbs.sel[0]) begin
        pause_q  <= wbs.dat_w[2];
        auto_q   <= wbs.dat_w[3];
        irq_en_q <= wbs.dat_w[4];
      end

      if (match_evt)     done_q <= 1'b1;
      else if (done_clr) done_q <= 1'b0;

      if (start && state == ST_IDLE) matches_q <= '0;
      else if (match_evt)            matches_q <= matches_q + 16'd1;
    end
  end

  assign ctr_load_data_o = load_q;
  assign irq_o           = done_q & irq_en_q;

endmodule
